parking_gate_arbiter: RTL and testbench
=======================================

# parking_gate_arbiter

Single-lane gate controller for the parking lot. Entry and exit lanes share one barrier gate. The block arbitrates the gate between the two lane requesters and keeps a saturating occupancy count. It consumes the one-cycle `entering`/`exiting` pulses from the lane sensor FSM to close the gate and update the count, and ends an open cycle on timeout if no car passes.

## Interface
- `CAPACITY`, 16: lot capacity, in cars.
- `CNT_W`, 5: occupancy counter width; must satisfy `CNT_W >= clog2(CAPACITY+1)`.
- `TIMEOUT`, 200: maximum cycles the gate stays open waiting for a pass pulse; range 1..2^TMR_W-1.
- `CLOSE_CYCLES`, 4: gate-lowering hold time, in cycles; range 1..2^TMR_W-1.
- `TMR_W`, 8: timer width.
- `clk`, in, 1: the single clock, rising edge.
- `rst`, in, 1: **asynchronous, active-low** reset.
- `entry_req`, in, 1: car waiting at the entry lane; level.
- `exit_req`, in, 1: car waiting at the exit lane; level.
- `entering`, in, 1: one-cycle pulse from the sensor FSM when a car completes entry.
- `exiting`, in, 1: one-cycle pulse from the sensor FSM when a car completes exit.
- `gate_open`, out, 1: barrier raise command.
- `grant_entry`, out, 1: entry lane currently owns the gate.
- `grant_exit`, out, 1: exit lane currently owns the gate.
- `count`, out, CNT_W: current occupancy.
- `full`, out, 1: `count == CAPACITY`.
- `empty`, out, 1: `count == 0`.
- `timeout_err`, out, 1: one-cycle pulse when an open cycle ends without a pass pulse.
- `seq_err`, out, 1: one-cycle pulse when a pass pulse does not match the current owner.

## Operation
- **States:** IDLE, OPEN_ENTRY, OPEN_EXIT, CLOSE. All outputs and state are registered, except `full`, `empty` and `gate_open`.
  - `full` and `empty` decode `count`.
  - `gate_open` is `grant_entry | grant_exit`.
- **Reset values (asynchronous, immediate, including mid-operation):** state IDLE, `count` 0, grants 0, `timeout_err` 0, `seq_err` 0, timer 0, `last_served` = EXIT.
- **IDLE eligibility:**
  - Entry is eligible when `entry_req && !full`.
  - Exit is eligible when `exit_req && !empty`.
- **IDLE arbitration:**
  - If only one lane is eligible, it wins.
  - If both are eligible, the lane opposite `last_served` wins. Entry therefore wins first after reset.
  - If neither is eligible, stay in IDLE.
  - The winner moves to OPEN_ENTRY or OPEN_EXIT, `last_served` is set to it, and the timer loads `TIMEOUT`.
- **OPEN_x, matching pulse** (`entering` in OPEN_ENTRY, `exiting` in OPEN_EXIT):
  - `count` moves ±1, saturating at 0 and `CAPACITY`.
  - Go to CLOSE; timer loads `CLOSE_CYCLES`.
- **OPEN_x, non-matching pulse:** pulse `seq_err`; `count` unchanged; remain open.
- **OPEN_x, timeout:** the timer decrements every cycle. When it is 1 and no matching pulse is present, pulse `timeout_err` and go to CLOSE.
- **Pulse and timeout on the same edge:** the pulse wins; count updates and `timeout_err` is not asserted.
- **Both pulses in the same cycle while OPEN:** the matching pulse is applied and `seq_err` is also pulsed.
- **CLOSE:**
  - Grants are 0; requests are ignored.
  - The timer decrements; at 1, go to IDLE.
- **Pulses outside OPEN:** any pulse while in IDLE or CLOSE asserts `seq_err`; `count` is unchanged.
- **Request drop:** dropping a request while OPEN has no effect; only a pulse or timeout ends the open cycle.

## Timing
- **Grant latency:** request sampled eligible at edge N → grant and `gate_open` high after edge N.
- **Full open cycle:** matching pulse at edge M → `count` updated and `gate_open` low after edge M; IDLE after edge M+`CLOSE_CYCLES`; earliest next grant after edge M+`CLOSE_CYCLES`+1.
- **Timeout:** with no pulse, the gate is high for exactly `TIMEOUT` cycles.
- **Error outputs:** `timeout_err` and `seq_err` are high for exactly one cycle each.

## Structure
- **Package `parking_pkg`:** state encoding (2-bit: IDLE=0, OPEN_ENTRY=1, OPEN_EXIT=2, CLOSE=3), lane enum for `last_served`, default `CAPACITY`/`TIMEOUT`/`CLOSE_CYCLES` constants.
- **Sub-module `gate_timer`:** TMR_W-bit down-counter with `load`, `load_val`, and a `last` (value == 1) flag. It is shared by the OPEN and CLOSE states.

## Test plan
1. Reset, then `entry_req`=1 → grant_entry and gate_open one cycle later; `entering` pulse → count 1, gate low, IDLE after 4 cycles.
2. Fill to 16 → `full`=1; a further `entry_req` receives no grant. An `exit_req` is granted; after the `exiting` pulse, count 15 and `full`=0.
3. Both requests held with count 5 → grants alternate entry, exit, entry across three full cycles; count ends at 6.
4. Grant entry with no pulse → `gate_open` high exactly 200 cycles, one-cycle `timeout_err`, count unchanged.
5. `exiting` pulse during OPEN_ENTRY, and any pulse in IDLE → `seq_err` pulse, count unchanged. An `entering` pulse on the same edge as timeout → count+1 and no `timeout_err`.
6. Assert `rst` low mid-OPEN_EXIT with count 7 → immediately count 0, gate_open 0, IDLE. After release, entry wins a simultaneous request.

Source files
------------

// File: rtl/parking_gate_arbiter_pkg.sv
// Shared types and default constants for the parking gate arbiter.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_OPEN_ENTRY = 2'd1,
        ST_OPEN_EXIT  = 2'd2,
        ST_CLOSE      = 2'd3
    } state_e;

    typedef enum logic {
        LANE_ENTRY = 1'b0,
        LANE_EXIT  = 1'b1
    } lane_e;

    localparam int DEF_CAPACITY     = 16;
    localparam int DEF_CNT_W        = 5;
    localparam int DEF_TIMEOUT      = 200;
    localparam int DEF_CLOSE_CYCLES = 4;
    localparam int DEF_TMR_W        = 8;

endpackage

// File: rtl/parking_gate_arbiter_if.sv
// Lane requests, sensor pulses and gate/occupancy status between lot logic and the arbiter.
interface parking_gate_if #(parameter int CNT_W = 5);

    logic             entry_req;
    logic             exit_req;
    logic             entering;
    logic             exiting;
    logic             gate_open;
    logic             grant_entry;
    logic             grant_exit;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             timeout_err;
    logic             seq_err;

    modport master (
        output entry_req, exit_req, entering, exiting,
        input  gate_open, grant_entry, grant_exit, count, full, empty, timeout_err, seq_err
    );

    modport slave (
        input  entry_req, exit_req, entering, exiting,
        output gate_open, grant_entry, grant_exit, count, full, empty, timeout_err, seq_err
    );

endinterface

// File: rtl/parking_gate_arbiter_gate_timer.sv
// Loadable down-counter that stops at zero; `last` flags the final counted cycle.
module gate_timer #(
    parameter int TMR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             last
);

    logic [TMR_W-1:0] value_q;
    logic [TMR_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_val;
        end else if (value_q != '0) begin
            value_d = value_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign last = (value_q == TMR_W'(1));

endmodule

// File: rtl/parking_gate_arbiter.sv
// Shares one barrier between entry and exit lanes, alternating on contention,
// and tracks lot occupancy from the sensor pass pulses.
module parking_gate_arbiter
    import parking_pkg::*;
#(
    parameter int CAPACITY     = DEF_CAPACITY,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES,
    parameter int TMR_W        = DEF_TMR_W
) (
    input  logic          clk,
    input  logic          rst,
    parking_gate_if.slave bus
);

    state_e           state_q, state_d;
    lane_e            last_q, last_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             grant_entry_q, grant_entry_d;
    logic             grant_exit_q, grant_exit_d;
    logic             timeout_err_q, timeout_err_d;
    logic             seq_err_q, seq_err_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_last;
    logic             full;
    logic             empty;
    logic             entry_elig;
    logic             exit_elig;

    assign full       = (count_q == CNT_W'(CAPACITY));
    assign empty      = (count_q == '0);
    assign entry_elig = bus.entry_req && !full;
    assign exit_elig  = bus.exit_req && !empty;

    gate_timer #(.TMR_W(TMR_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .last     (tmr_last)
    );

    // A matching pass pulse beats a simultaneous timeout; a wrong-lane pulse is flagged but never counted.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        count_d       = count_q;
        grant_entry_d = 1'b0;
        grant_exit_d  = 1'b0;
        timeout_err_d = 1'b0;
        seq_err_d     = 1'b0;
        tmr_load      = 1'b0;
        tmr_load_val  = TMR_W'(TIMEOUT);

        unique case (state_q)
            ST_IDLE: begin
                seq_err_d = bus.entering | bus.exiting;
                if (entry_elig && (!exit_elig || last_q == LANE_EXIT)) begin
                    state_d       = ST_OPEN_ENTRY;
                    last_d        = LANE_ENTRY;
                    grant_entry_d = 1'b1;
                    tmr_load      = 1'b1;
                end else if (exit_elig) begin
                    state_d      = ST_OPEN_EXIT;
                    last_d       = LANE_EXIT;
                    grant_exit_d = 1'b1;
                    tmr_load     = 1'b1;
                end
            end
            ST_OPEN_ENTRY: begin
                grant_entry_d = 1'b1;
                seq_err_d     = bus.exiting;
                if (bus.entering) begin
                    if (!full) begin
                        count_d = count_q + 1'b1;
                    end
                    state_d       = ST_CLOSE;
                    grant_entry_d = 1'b0;
                    tmr_load      = 1'b1;
                    tmr_load_val  = TMR_W'(CLOSE_CYCLES);
                end else if (tmr_last) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_CLOSE;
                    grant_entry_d = 1'b0;
                    tmr_load      = 1'b1;
                    tmr_load_val  = TMR_W'(CLOSE_CYCLES);
                end
            end
            ST_OPEN_EXIT: begin
                grant_exit_d = 1'b1;
                seq_err_d    = bus.entering;
                if (bus.exiting) begin
                    if (!empty) begin
                        count_d = count_q - 1'b1;
                    end
                    state_d      = ST_CLOSE;
                    grant_exit_d = 1'b0;
                    tmr_load     = 1'b1;
                    tmr_load_val = TMR_W'(CLOSE_CYCLES);
                end else if (tmr_last) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_CLOSE;
                    grant_exit_d  = 1'b0;
                    tmr_load      = 1'b1;
                    tmr_load_val  = TMR_W'(CLOSE_CYCLES);
                end
            end
            ST_CLOSE: begin
                seq_err_d = bus.entering | bus.exiting;
                if (tmr_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            last_q        <= LANE_EXIT;
            count_q       <= '0;
            grant_entry_q <= 1'b0;
            grant_exit_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            count_q       <= count_d;
            grant_entry_q <= grant_entry_d;
            grant_exit_q  <= grant_exit_d;
            timeout_err_q <= timeout_err_d;
            seq_err_q     <= seq_err_d;
        end
    end

    assign bus.grant_entry = grant_entry_q;
    assign bus.grant_exit  = grant_exit_q;
    assign bus.gate_open   = grant_entry_q | grant_exit_q;
    assign bus.count       = count_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.timeout_err = timeout_err_q;
    assign bus.seq_err     = seq_err_q;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed scenarios plus random traffic for the parking gate arbiter, checked
// every cycle against a lane-ownership / countdown model of the gate.
module tb_parking_gate_arbiter;

    localparam int CAP = 16;
    localparam int TMO = 200;
    localparam int CLS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    parking_gate_if #(.CNT_W(5)) bus();

    parking_gate_arbiter #(
        .CAPACITY     (CAP),
        .CNT_W        (5),
        .TIMEOUT      (TMO),
        .CLOSE_CYCLES (CLS),
        .TMR_W        (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    // Model: who owns the gate (0 none, 1 entry, 2 exit), cycles left open or closing, cars in lot.
    int m_owner      = 0;
    int m_open_left  = 0;
    int m_close_left = 0;
    int m_count      = 0;
    int m_last       = 2;
    int m_terr       = 0;
    int m_serr       = 0;
    bit m_e_el;
    bit m_x_el;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner = 0; m_open_left = 0; m_close_left = 0;
            m_count = 0; m_last = 2; m_terr = 0; m_serr = 0;
        end else begin
            m_terr = 0;
            m_serr = 0;
            if (m_owner != 0) begin
                if ((m_owner == 1) ? bus.exiting : bus.entering) m_serr = 1;
                if ((m_owner == 1) ? bus.entering : bus.exiting) begin
                    if (m_owner == 1) m_count = (m_count < CAP) ? m_count + 1 : CAP;
                    else              m_count = (m_count > 0) ? m_count - 1 : 0;
                    m_owner = 0;
                    m_close_left = CLS;
                end else if (m_open_left == 1) begin
                    m_terr = 1;
                    m_owner = 0;
                    m_close_left = CLS;
                end else begin
                    m_open_left--;
                end
            end else if (m_close_left > 0) begin
                if (bus.entering || bus.exiting) m_serr = 1;
                m_close_left--;
            end else begin
                if (bus.entering || bus.exiting) m_serr = 1;
                m_e_el = bus.entry_req && (m_count < CAP);
                m_x_el = bus.exit_req && (m_count > 0);
                if (m_e_el && m_x_el) m_owner = (m_last == 1) ? 2 : 1;
                else if (m_e_el)      m_owner = 1;
                else if (m_x_el)      m_owner = 2;
                if (m_owner != 0) begin
                    m_last = m_owner;
                    m_open_left = TMO;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("grant_entry", int'(bus.grant_entry), int'(m_owner == 1));
            checkOutput("grant_exit",  int'(bus.grant_exit),  int'(m_owner == 2));
            checkOutput("gate_open",   int'(bus.gate_open),   int'(m_owner != 0));
            checkOutput("count",       int'(bus.count),       m_count);
            checkOutput("full",        int'(bus.full),        int'(m_count == CAP));
            checkOutput("empty",       int'(bus.empty),       int'(m_count == 0));
            checkOutput("timeout_err", int'(bus.timeout_err), m_terr);
            checkOutput("seq_err",     int'(bus.seq_err),     m_serr);
        end
    end

    task automatic applyStimulus(input bit er, input bit xr, input bit en, input bit ex);
        bus.entry_req = er;
        bus.exit_req  = xr;
        bus.entering  = en;
        bus.exiting   = ex;
        @(negedge clk);
    endtask

    task automatic waitGrant(input bit er, input bit xr, output int lane);
        lane = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(er, xr, 1'b0, 1'b0);
            if (bus.gate_open) begin
                lane = bus.grant_entry ? 1 : 2;
                break;
            end
        end
        tests++;
        if (lane == 0) begin
            fails++;
            $display("[TB] FAIL grant_wait: gate_open stayed 0 for 30 cycles, expected 1 at %0t", $time);
        end
    endtask

    task automatic carPass(input int lane);
        int got;
        if (lane == 1) waitGrant(1'b1, 1'b0, got);
        else           waitGrant(1'b0, 1'b1, got);
        if (got != 0) applyStimulus(1'b0, 1'b0, got == 1, got == 2);
        repeat (CLS) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int lane;
        int high;
        int terr_seen;
        bit er, xr, en, ex;

        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        bus.entering  = 1'b0;
        bus.exiting   = 1'b0;
        #1 rst = 1'b0;
        check_en = 1'b1;
        repeat (2) applyStimulus(0, 0, 0, 0);
        checkOutput("reset_count", int'(bus.count), 0);
        checkOutput("reset_empty", int'(bus.empty), 1);
        checkOutput("reset_gate",  int'(bus.gate_open), 0);
        rst = 1'b1;

        // First car: grant one edge after request, gate drops on the pass pulse, re-grant only after close.
        applyStimulus(1, 0, 0, 0);
        checkOutput("t1_grant_entry", int'(bus.grant_entry), 1);
        checkOutput("t1_gate_open",   int'(bus.gate_open), 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("t1_count",     int'(bus.count), 1);
        checkOutput("t1_gate_low",  int'(bus.gate_open), 0);
        for (int i = 0; i < CLS; i++) begin
            applyStimulus(1, 0, 0, 0);
            checkOutput("t1_close_hold", int'(bus.gate_open), 0);
        end
        applyStimulus(1, 0, 0, 0);
        checkOutput("t1_regrant", int'(bus.gate_open), 1);
        applyStimulus(0, 0, 1, 0);
        repeat (CLS) applyStimulus(0, 0, 0, 0);

        // Fill the lot, then only exit may be served.
        repeat (CAP - 2) carPass(1);
        checkOutput("t2_count_full", int'(bus.count), 16);
        checkOutput("t2_full",       int'(bus.full), 1);
        repeat (10) applyStimulus(1, 0, 0, 0);
        checkOutput("t2_no_grant_full", int'(bus.gate_open), 0);
        waitGrant(1, 1, lane);
        checkOutput("t2_exit_lane", lane, 2);
        applyStimulus(1, 0, 0, 1);
        checkOutput("t2_count_15", int'(bus.count), 15);
        checkOutput("t2_not_full", int'(bus.full), 0);
        repeat (CLS) applyStimulus(0, 0, 0, 0);

        // Contention alternates lanes, starting with entry since exit was served last.
        repeat (10) carPass(2);
        checkOutput("t3_count_5", int'(bus.count), 5);
        for (int r = 0; r < 3; r++) begin
            waitGrant(1, 1, lane);
            checkOutput("t3_alt_lane", lane, (r == 1) ? 2 : 1);
            applyStimulus(1, 1, lane == 1, lane == 2);
            repeat (CLS) applyStimulus(1, 1, 0, 0);
        end
        applyStimulus(0, 0, 0, 0);
        checkOutput("t3_count_6", int'(bus.count), 6);
        repeat (CLS + 2) applyStimulus(0, 0, 0, 0);

        // Timeout with no pass pulse.
        waitGrant(1, 0, lane);
        high = 1;
        terr_seen = 0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(0, 0, 0, 0);
            if (bus.timeout_err) terr_seen++;
            if (!bus.gate_open) break;
            high++;
        end
        for (int i = 0; i < CLS; i++) begin
            applyStimulus(0, 0, 0, 0);
            if (bus.timeout_err) terr_seen++;
        end
        checkOutput("t4_open_cycles", high, 200);
        checkOutput("t4_timeout_pulses", terr_seen, 1);
        checkOutput("t4_count", int'(bus.count), 6);

        // Pass pulse on the same edge the timer would expire.
        waitGrant(1, 0, lane);
        repeat (TMO - 1) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("t5_edge_count",   int'(bus.count), 7);
        checkOutput("t5_edge_no_tmo",  int'(bus.timeout_err), 0);
        checkOutput("t5_edge_gate",    int'(bus.gate_open), 0);
        repeat (CLS) applyStimulus(0, 0, 0, 0);

        // Wrong-lane pulse while open, pulse while idle, and both pulses together.
        waitGrant(1, 0, lane);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t5_seq_open",   int'(bus.seq_err), 1);
        checkOutput("t5_seq_count",  int'(bus.count), 7);
        checkOutput("t5_still_open", int'(bus.gate_open), 1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t5_seq_one_cycle", int'(bus.seq_err), 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("t5_count_8", int'(bus.count), 8);
        repeat (CLS) applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("t5_seq_idle",       int'(bus.seq_err), 1);
        checkOutput("t5_seq_idle_count", int'(bus.count), 8);
        waitGrant(1, 0, lane);
        applyStimulus(0, 0, 1, 1);
        checkOutput("t5_both_count", int'(bus.count), 9);
        checkOutput("t5_both_seq",   int'(bus.seq_err), 1);
        repeat (CLS) applyStimulus(0, 0, 0, 0);

        // Asynchronous reset in the middle of an exit cycle.
        repeat (2) carPass(2);
        checkOutput("t6_count_7", int'(bus.count), 7);
        waitGrant(0, 1, lane);
        checkOutput("t6_exit_lane", lane, 2);
        applyStimulus(0, 1, 0, 0);
        #3 rst = 1'b0;
        #1;
        checkOutput("t6_rst_count", int'(bus.count), 0);
        checkOutput("t6_rst_gate",  int'(bus.gate_open), 0);
        checkOutput("t6_rst_grant", int'(bus.grant_exit), 0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1, 1, 0, 0);
        checkOutput("t6_entry_first", int'(bus.grant_entry), 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("t6_count_1", int'(bus.count), 1);
        repeat (CLS) applyStimulus(0, 0, 0, 0);

        // Random traffic; pulses are more likely for the lane that currently owns the gate.
        for (int i = 0; i < 3000; i++) begin
            er = ($urandom_range(0, 3) != 0);
            xr = ($urandom_range(0, 3) != 0);
            en = (m_owner == 1) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 40) == 0);
            ex = (m_owner == 2) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 40) == 0);
            applyStimulus(er, xr, en, ex);
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
